result_serializer: RTL and testbench

Output-side companion to the column-loading shift register of the cascade multiplier bench. It captures the parallel result bits produced by the compressor (dst0..dst17 for mul9) in one cycle. It then shifts them out one bit per clock on a single serial pin, with a valid qualifier, a stall input and an end-of-frame pulse. This lets the bench or a pin-limited FPGA wrapper read results over one wire, the same way operands are fed in.

---
 rtl/result_serializer.sv | 105 ++++++++++
 tb/tb_result_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// result_serializer: captures a WIDTH-bit compressor result in one cycle. It then shifts the
// word out one bit per clock on a single serial pin. The pin has a valid qualifier, a stall
// input and a one-cycle end-of-frame pulse (done).
// Optional feature: define RESULT_PARITY_EN to append an even-parity bit after the data bits.
// This makes the frame WIDTH+1 bits long.
module result_serializer #(
    parameter int unsigned WIDTH     = 18,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] src,
    input  logic             load,
    input  logic             stall,
    output logic             dst_,
    output logic             dst_valid,
    output logic             busy,
    output logic             done
);

`ifdef RESULT_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    // Set on the edge that emits the last frame bit, so done lands one cycle later.
    logic             done_pend;
    logic             next_bit;
    logic [WIDTH-1:0] sreg_shifted;
`ifdef RESULT_PARITY_EN
    logic             par;
`endif

    // Select the bit to emit and the shifted register contents (zero fill).
    always_comb begin
        sreg_shifted = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
        next_bit     = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
`ifdef RESULT_PARITY_EN
        // After all data bits have gone out, the trailing frame bit is the parity.
        if (cnt == CW'(WIDTH)) begin
            next_bit = par;
        end
`endif
    end

    // Control FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            sreg      <= '0;
            cnt       <= '0;
            done_pend <= 1'b0;
            dst_      <= 1'b0;
            dst_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef RESULT_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            done      <= done_pend;
            done_pend <= 1'b0;
            unique case (state)
                StIdle: begin
                    dst_valid <= 1'b0;
                    busy      <= 1'b0;
                    if (load) begin
                        state <= StShift;
                        sreg  <= src;
                        cnt   <= '0;
                        busy  <= 1'b1;
`ifdef RESULT_PARITY_EN
                        par   <= ^src;
`endif
                    end
                end
                StShift: begin
                    if (stall) begin
                        // dst_ keeps its last value; only the qualifier drops.
                        dst_valid <= 1'b0;
                    end else begin
                        dst_      <= next_bit;
                        dst_valid <= 1'b1;
                        sreg      <= sreg_shifted;
                        cnt       <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state     <= StIdle;
                            busy      <= 1'b0;
                            done_pend <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer. It drives an LSB-first and an MSB-first instance from the
// same stimulus. The checks come from a vector table and a few hand-written sequences:
// back-to-back frames and reset mid-frame.
module tb_result_serializer;

    localparam int unsigned WIDTH = 18;
`ifdef RESULT_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load;
    logic             stall;
    logic [WIDTH-1:0] src;
    logic             dst_l, valid_l, busy_l, done_l;
    logic             dst_m, valid_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;
    int quiet;

    always #5 clk = ~clk;

    result_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .src(src), .load(load), .stall(stall),
        .dst_(dst_l), .dst_valid(valid_l), .busy(busy_l), .done(done_l)
    );

    result_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .src(src), .load(load), .stall(stall),
        .dst_(dst_m), .dst_valid(valid_m), .busy(busy_m), .done(done_m)
    );

    // exp_msb holds the MSB-first stream with stream bit k at bit k (hand-reversed src).
    typedef struct {
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] exp_msb;
        logic             par;
        int               ss;
        int               sl;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts one cycle after an edge with both DUTs idle. The stall is high for the edges
    // T+ss .. T+ss+sl-1. Returns at cycle T+FRAME+1+sl, which is the expected done cycle.
    task automatic run_frame(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] exp_m,
                             input logic par, input int ss, input int sl,
                             input logic [WIDTH-1:0] w2, input bit hold);
        logic [FRAME-1:0] exp_l_s, exp_m_s;
        logic [WIDTH:0]   got_l, got_m;
        int               n_l, n_m, done_at_l, done_at_m, stall_bad, dc;
        logic             busy1;
        got_l     = '0;
        got_m     = '0;
        n_l       = 0;
        n_m       = 0;
        done_at_l = -1;
        done_at_m = -1;
        stall_bad = 0;
        busy1     = 1'b0;
        exp_l_s   = FRAME'({par, w});
        exp_m_s   = FRAME'({par, exp_m});
        dc        = FRAME + 1 + sl;

        src   = w;
        load  = 1'b1;
        stall = 1'b0;
        @(posedge clk); #1;
        // Capture edge T has passed; later src changes must not leak into this frame.
        src = w2;
        if (!hold) load = 1'b0;
        for (int c = 1; c <= dc; c++) begin
            stall = (c >= ss) && (c < ss + sl);
            if (!hold) load = (c == 5);
            @(posedge clk); #1;
            if (valid_l) begin
                if (n_l <= int'(WIDTH)) got_l[n_l] = dst_l;
                n_l++;
            end
            if (valid_m) begin
                if (n_m <= int'(WIDTH)) got_m[n_m] = dst_m;
                n_m++;
            end
            if (stall && (valid_l || valid_m)) stall_bad++;
            if (done_l && done_at_l < 0) done_at_l = c;
            if (done_m && done_at_m < 0) done_at_m = c;
            if (c == 1) busy1 = busy_l & busy_m;
        end
        stall = 1'b0;

        check("lsb_bits", 32'(got_l[FRAME-1:0]), 32'(exp_l_s));
        check("msb_bits", 32'(got_m[FRAME-1:0]), 32'(exp_m_s));
        check("lsb_valid_count", 32'(n_l), 32'(FRAME));
        check("msb_valid_count", 32'(n_m), 32'(FRAME));
        check("lsb_done_cycle", 32'(done_at_l), 32'(dc));
        check("msb_done_cycle", 32'(done_at_m), 32'(dc));
        check("no_valid_in_stall", 32'(stall_bad), 32'd0);
        check("busy_after_capture", 32'(busy1), 32'd1);
        if (!hold) check("idle_in_done_cycle", 32'({busy_l, busy_m, valid_l, valid_m}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{18'h2A5C3, 18'h30E95, 1'b1, 0, 0};
        vecs[1] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 3, 3};
        vecs[2] = '{18'h00003, 18'h30000, 1'b0, 0, 0};
        vecs[3] = '{18'h00000, 18'h00000, 1'b0, 1, 1};
        vecs[4] = '{18'h20001, 18'h20001, 1'b0, 18, 2};
        vecs[5] = '{18'h15555, 18'h2AAAA, 1'b1, 10, 1};

        // Reset, with load high to confirm that reset wins.
        rst_n = 1'b0;
        load  = 1'b1;
        stall = 1'b0;
        src   = 18'h2A5C3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({dst_l, valid_l, busy_l, done_l, dst_m, valid_m, busy_m, done_m}), 32'd0);
        rst_n = 1'b1;
        load  = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].src, vecs[i].exp_msb, vecs[i].par, vecs[i].ss, vecs[i].sl,
                      ~vecs[i].src, 1'b0);
        end

        // Back-to-back: load is held through done, so the second word is captured in the done cycle.
        run_frame(18'h2A5C3, 18'h30E95, 1'b1, 0, 0, 18'h00001, 1'b1);
        @(posedge clk); #1;
        check("b2b_first_valid", 32'({valid_l, valid_m}), 32'b11);
        check("b2b_first_bit", 32'({dst_l, dst_m}), 32'b10);

        // Reset seven edges into the second frame, with load and stall high.
        load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        load  = 1'b1;
        stall = 1'b1;
        @(posedge clk); #1;
        check("midframe_reset",
              32'({dst_l, valid_l, busy_l, done_l, dst_m, valid_m, busy_m, done_m}), 32'd0);
        rst_n = 1'b1;
        load  = 1'b0;
        stall = 1'b0;
        quiet = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid_l || valid_m || busy_l || busy_m || done_l || done_m) quiet++;
        end
        check("post_reset_quiet", 32'(quiet), 32'd0);

        // A fresh frame after reset starts from bit 0.
        run_frame(18'h2A5C3, 18'h30E95, 1'b1, 0, 0, 18'h3FFFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
